// File: rtl/full_adder_unit_if.sv
// Bundles the full-adder operand, result and serial-add signals of full_adder_unit.
// The master drives operands and serial start; the slave (the adder) drives results.
interface full_adder_unit_if #(
    parameter int unsigned SER_W = 8
);
    logic             in1;
    logic             in2;
    logic             cin;
    logic             sum;
    logic             cout;
    logic             sum_q;
    logic             cout_q;
    logic             ser_start;
    logic             ser_busy;
    logic             ser_done;
    logic [SER_W-1:0] ser_result;
    logic             ser_cout;

    modport master (
        output in1, in2, cin, ser_start,
        input  sum, cout, sum_q, cout_q, ser_busy, ser_done, ser_result, ser_cout
    );

    modport slave (
        input  in1, in2, cin, ser_start,
        output sum, cout, sum_q, cout_q, ser_busy, ser_done, ser_result, ser_cout
    );
endinterface

// File: rtl/full_adder_unit.sv
// Single-bit full adder with registered outputs and an LSB-first bit-serial
// SER_W-bit adder that reuses the same sum/majority cell every clock.
module full_adder_unit #(
    parameter int unsigned SER_W = 8
) (
    input logic              clk,
    input logic              rst,
    full_adder_unit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(SER_W);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } ser_state_e;

    ser_state_e       state_q, state_d;
    logic             reg_sum_q, reg_sum_d;
    logic             reg_cout_q, reg_cout_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SER_W-1:0] acc_q, acc_d;
    logic             done_q, done_d;
    logic [SER_W-1:0] result_q, result_d;
    logic             ser_cout_q, ser_cout_d;

    logic             sum_c;
    logic             cout_c;
    logic             bit_cin;
    logic             bit_sum;
    logic             bit_carry;

    always_comb begin
        sum_c  = bus.in1 ^ bus.in2 ^ bus.cin;
        cout_c = (bus.in1 & bus.in2) | (bus.in1 & bus.cin) | (bus.in2 & bus.cin);
    end

    // The serial cell takes the external carry only on the start edge.
    always_comb begin
        bit_cin   = bus.ser_start ? bus.cin : carry_q;
        bit_sum   = bus.in1 ^ bus.in2 ^ bit_cin;
        bit_carry = (bus.in1 & bus.in2) | (bus.in1 & bit_cin) | (bus.in2 & bit_cin);
    end

    always_comb begin
        reg_sum_d  = sum_c;
        reg_cout_d = cout_c;
        state_d    = state_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        done_d     = 1'b0;
        result_d   = result_q;
        ser_cout_d = ser_cout_q;

        if (bus.ser_start) begin
            acc_d[0] = bit_sum;
            carry_d  = bit_carry;
            cnt_d    = CNT_W'(1);
            state_d  = S_BUSY;
        end else begin
            case (state_q)
                S_BUSY: begin
                    acc_d[cnt_q] = bit_sum;
                    carry_d      = bit_carry;
                    cnt_d        = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(SER_W - 1)) begin
                        state_d    = S_IDLE;
                        done_d     = 1'b1;
                        result_d   = acc_d;
                        ser_cout_d = bit_carry;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            reg_sum_q  <= 1'b0;
            reg_cout_q <= 1'b0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
            ser_cout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_sum_q  <= reg_sum_d;
            reg_cout_q <= reg_cout_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            done_q     <= done_d;
            result_q   <= result_d;
            ser_cout_q <= ser_cout_d;
        end
    end

    assign bus.sum        = sum_c;
    assign bus.cout       = cout_c;
    assign bus.sum_q      = reg_sum_q;
    assign bus.cout_q     = reg_cout_q;
    assign bus.ser_busy   = (state_q == S_BUSY);
    assign bus.ser_done   = done_q;
    assign bus.ser_result = result_q;
    assign bus.ser_cout   = ser_cout_q;
endmodule

// File: tb/tb_full_adder_unit.sv
// Directed bench for full_adder_unit: combinational, registered and serial-add
// behaviour, with serial results checked through an expected-value queue.
module tb_full_adder_unit;
    localparam int unsigned SER_W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [SER_W:0] sb[$];

    full_adder_unit_if #(.SER_W(SER_W)) bus ();

    full_adder_unit #(.SER_W(SER_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives nbits of an LSB-first add; a full-length add is pushed to the
    // scoreboard on its start bit and popped when ser_done is expected.
    task automatic run_add(input string tag, input logic [SER_W-1:0] a, input logic [SER_W-1:0] b,
                           input logic c, input int unsigned nbits);
        logic [SER_W:0] exp;
        for (int unsigned k = 0; k < nbits; k++) begin
            @(negedge clk);
            bus.ser_start = (k == 0);
            bus.in1       = a[k];
            bus.in2       = b[k];
            bus.cin       = (k == 0) ? c : 1'b1;
            if (k == 0 && nbits == SER_W)
                sb.push_back({1'b0, a} + {1'b0, b} + {{SER_W{1'b0}}, c});
            @(posedge clk);
            #1;
            if (k == SER_W - 1) begin
                check({tag, " done"}, 64'(bus.ser_done), 64'd1);
                check({tag, " busy_end"}, 64'(bus.ser_busy), 64'd0);
                exp = sb.pop_front();
                check({tag, " result"}, 64'({bus.ser_cout, bus.ser_result}), 64'(exp));
            end else begin
                check({tag, " no_done"}, 64'(bus.ser_done), 64'd0);
                check({tag, " busy"}, 64'(bus.ser_busy), 64'd1);
            end
        end
    endtask

    task automatic idle_after(input string tag, input logic [SER_W:0] held);
        @(negedge clk);
        bus.ser_start = 1'b0;
        bus.in1 = 1'b1; bus.in2 = 1'b1; bus.cin = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " done_pulse_end"}, 64'(bus.ser_done), 64'd0);
        check({tag, " held"}, 64'({bus.ser_cout, bus.ser_result}), 64'(held));
    endtask

    initial begin
        logic a, b, c;
        logic exp_s, exp_c;
        rst = 1'b0;
        bus.in1 = 1'b0; bus.in2 = 1'b0; bus.cin = 1'b0; bus.ser_start = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst sum_q", 64'(bus.sum_q), 64'd0);
        check("rst cout_q", 64'(bus.cout_q), 64'd0);
        check("rst busy", 64'(bus.ser_busy), 64'd0);
        check("rst done", 64'(bus.ser_done), 64'd0);
        check("rst result", 64'({bus.ser_cout, bus.ser_result}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a = 1'(i >> 2); b = 1'(i >> 1); c = 1'(i);
            bus.in1 = a; bus.in2 = b; bus.cin = c;
            exp_s = 1'((int'(a) + int'(b) + int'(c)) % 2);
            exp_c = (int'(a) + int'(b) + int'(c)) >= 2;
            #1;
            check($sformatf("comb sum %0d", i), 64'(bus.sum), 64'(exp_s));
            check($sformatf("comb cout %0d", i), 64'(bus.cout), 64'(exp_c));
        end

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a = 1'($urandom_range(1)); b = 1'($urandom_range(1)); c = 1'($urandom_range(1));
            bus.in1 = a; bus.in2 = b; bus.cin = c;
            exp_s = a ^ b ^ c;
            exp_c = (a & b) | (a & c) | (b & c);
            #1;
            check("rand sum", 64'(bus.sum), 64'(exp_s));
            check("rand cout", 64'(bus.cout), 64'(exp_c));
            @(posedge clk);
            #1;
            check("rand sum_q", 64'(bus.sum_q), 64'(exp_s));
            check("rand cout_q", 64'(bus.cout_q), 64'(exp_c));
        end

        @(negedge clk);
        bus.in1 = 1'b1; bus.in2 = 1'b1; bus.cin = 1'b0;
        @(posedge clk);
        #1;
        check("reg sum_q", 64'(bus.sum_q), 64'd0);
        check("reg cout_q", 64'(bus.cout_q), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async sum_q", 64'(bus.sum_q), 64'd0);
        check("async cout_q", 64'(bus.cout_q), 64'd0);
        check("rst comb cout", 64'(bus.cout), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        run_add("add 3+5", 8'h03, 8'h05, 1'b0, SER_W);
        run_add("add ff+01", 8'hFF, 8'h01, 1'b0, SER_W);
        run_add("add ff+00+1", 8'hFF, 8'h00, 1'b1, SER_W);
        idle_after("after ff", 9'h100);

        run_add("abandoned", 8'h0F, 8'h0F, 1'b0, 4);
        run_add("restart", 8'h10, 8'h20, 1'b0, SER_W);
        idle_after("after restart", 9'h030);

        run_add("to reset", 8'h55, 8'h33, 1'b0, 3);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid rst busy", 64'(bus.ser_busy), 64'd0);
        check("mid rst done", 64'(bus.ser_done), 64'd0);
        check("mid rst result", 64'({bus.ser_cout, bus.ser_result}), 64'd0);
        @(posedge clk);
        #1;
        check("held rst busy", 64'(bus.ser_busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_add("post rst", 8'h7A, 8'h86, 1'b1, SER_W);
        idle_after("post rst", 9'h101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end
endmodule
